// File: rtl/xor_cipher_cfg_ctrl.sv
// Loads a key into an XOR cipher's serial config chain, re-shifts it to verify
// the readback, and gates the cipher on a clean verify. Also provides a liveness heartbeat.
module xor_cipher_cfg_ctrl #(
    parameter int CFG_LEN = 8,
    parameter int HB_BITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_req,
    input  logic [CFG_LEN-1:0] load_data,
    output logic               load_rdy,
    output logic               cfg_en,
    output logic               cfg_sd,
    input  logic               cfg_so,
    output logic               cipher_en,
    output logic               done,
    output logic               err,
    output logic               heartbeat
);

    localparam int CNT_W = (CFG_LEN > 1) ? $clog2(CFG_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        VERIFY,
        RUN,
        FAULT
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CFG_LEN-1:0]   shadow;
    logic                 mismatch;
    logic [HB_BITS-1:0]   hb_cnt;

    logic accept;
    logic shadow_bit;
    logic bit_last;
    logic bit_miss;

    // Handshake and chain outputs decode straight from registered state only.
    assign load_rdy   = (state == IDLE) || (state == RUN) || (state == FAULT);
    assign cfg_en     = (state == SHIFT) || (state == VERIFY);
    assign shadow_bit = shadow[bit_cnt];
    assign cfg_sd     = cfg_en & shadow_bit;
    assign accept     = load_req & load_rdy;
    assign bit_last   = (bit_cnt == CNT_LAST);
    assign bit_miss   = (cfg_so != shadow_bit);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the async reset clears all state, including the shadow key.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shadow    <= '0;
            mismatch  <= 1'b0;
            cipher_en <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, RUN, FAULT: begin
                    if (accept) begin
                        shadow    <= load_data;
                        bit_cnt   <= '0;
                        mismatch  <= 1'b0;
                        err       <= 1'b0;
                        cipher_en <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        state   <= VERIFY;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                VERIFY: begin
                    mismatch <= mismatch | bit_miss;
                    if (bit_last) begin
                        bit_cnt <= '0;
                        // The final bit's compare must be folded in here, not via the flag.
                        if (mismatch || bit_miss) begin
                            err       <= 1'b1;
                            cipher_en <= 1'b0;
                            state     <= FAULT;
                        end else begin
                            done      <= 1'b1;
                            cipher_en <= 1'b1;
                            state     <= RUN;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hb_cnt    <= '0;
            heartbeat <= 1'b0;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
            if (&hb_cnt) begin
                heartbeat <= ~heartbeat;
            end
        end
    end

endmodule

// File: tb/tb_xor_cipher_cfg_ctrl.sv
// Directed plus randomized bench for xor_cipher_cfg_ctrl, with an 8-stage
// cipher chain model (optional stuck-at-0 output) and a key-level reference model.
module tb_xor_cipher_cfg_ctrl;

    logic       clk;
    logic       rst;
    logic       load_req;
    logic [7:0] load_data;
    logic       load_rdy;
    logic       cfg_en;
    logic       cfg_sd;
    logic       cfg_so;
    logic       cipher_en;
    logic       done;
    logic       err;
    logic       heartbeat;

    logic [7:0] chain;
    logic       stuck;
    int         n_checks;
    int         n_fail;
    int         hb_edges;

    xor_cipher_cfg_ctrl #(.CFG_LEN(8), .HB_BITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_req  (load_req),
        .load_data (load_data),
        .load_rdy  (load_rdy),
        .cfg_en    (cfg_en),
        .cfg_sd    (cfg_sd),
        .cfg_so    (cfg_so),
        .cipher_en (cipher_en),
        .done      (done),
        .err       (err),
        .heartbeat (heartbeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cipher chain: bit enters stage 0, cfg_so views stage 7.
    always @(posedge clk) begin
        if (cfg_en) chain <= {chain[6:0], cfg_sd};
    end
    assign cfg_so = stuck ? 1'b0 : chain[7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Heartbeat expectation: flips every 16 rising edges counted from reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) hb_edges <= 0;
        else      hb_edges <= hb_edges + 1;
    end
    always @(negedge clk) begin
        check("heartbeat", 32'(heartbeat), 32'((hb_edges / 16) % 2));
    end

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
    endfunction

    // Starts just after a negedge with load_rdy expected high; ends just after a negedge.
    task automatic do_load(input logic [7:0] key);
        logic [7:0] readback;
        logic       pass;
        readback = stuck ? 8'h00 : key;
        pass     = (readback == key);
        check("rdy_before_accept", 32'(load_rdy), 32'd1);
        load_req  = 1'b1;
        load_data = key;
        @(posedge clk);
        #1;
        load_req  = 1'b0;
        load_data = 8'($urandom);
        check("cipher_en_drop_on_accept", 32'(cipher_en), 32'd0);
        check("err_clear_on_accept", 32'(err), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check("shift_flags{en,rdy,done}", 32'({cfg_en, load_rdy, done}), 32'b100);
            check("cfg_sd_bit", 32'(cfg_sd), 32'(key[(i - 1) % 8]));
        end
        @(negedge clk);
        check("done_at_17", 32'(done), 32'(pass));
        check("cipher_en_at_17", 32'(cipher_en), 32'(pass));
        check("err_at_17", 32'(err), 32'(!pass));
        check("idle_chain_outputs{rdy,en,sd}", 32'({load_rdy, cfg_en, cfg_sd}), 32'b100);
        if (pass) check("chain_holds_key", 32'(chain), 32'(rev8(key)));
        @(negedge clk);
        check("done_single_cycle", 32'(done), 32'd0);
        check("cipher_en_hold", 32'(cipher_en), 32'(pass));
        check("err_hold", 32'(err), 32'(!pass));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        load_req  = 1'b0;
        load_data = 8'h00;
        stuck     = 1'b0;
        chain     = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({load_rdy, cfg_en, cfg_sd, cipher_en, done, err, heartbeat}), 32'b1000000);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic load and key change while running.
        do_load(8'hA5);
        repeat (3) @(negedge clk);
        do_load(8'h5A);

        // Stuck-at-0 chain output, then repair.
        stuck = 1'b1;
        do_load(8'hFF);
        repeat (5) @(negedge clk);
        check("fault_persist{rdy,cip,done,err}", 32'({load_rdy, cipher_en, done, err}), 32'b1001);
        stuck = 1'b0;
        do_load(8'h3C);

        // Randomized keys, some loaded through a stuck chain.
        for (int n = 0; n < 6; n++) begin
            stuck = (n % 3 == 2) ? 1'($urandom) : 1'b0;
            do_load(8'($urandom));
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        stuck = 1'b0;

        // Reset in SHIFT cycle 3 aborts the load; held reset blocks accepts.
        load_req  = 1'b1;
        load_data = 8'hC3;
        @(posedge clk);
        #1 load_req = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_reset_outputs", 32'({load_rdy, cfg_en, cfg_sd, cipher_en, done, err, heartbeat}), 32'b1000000);
        load_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("no_accept_in_reset{rdy,en}", 32'({load_rdy, cfg_en}), 32'b10);
        load_req = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("cipher_en_after_abort", 32'(cipher_en), 32'd0);
        do_load(8'h81);

        // load_req held high from reset: back-to-back loads.
        @(negedge clk);
        rst       = 1'b0;
        load_req  = 1'b1;
        load_data = 8'h0F;
        @(negedge clk);
        rst = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i <= 16; i++) begin
                @(negedge clk);
                check("b2b_busy{rdy,done,en}", 32'({load_rdy, done, cfg_en}), 32'b001);
            end
            @(negedge clk);
            check("b2b_done{rdy,done,cip}", 32'({load_rdy, done, cipher_en}), 32'b111);
            check("b2b_chain", 32'(chain), 32'(rev8(8'h0F)));
            if (r == 2) load_req = 1'b0;
        end
        @(posedge clk);
        #1;
        check("b2b_release_cipher_en", 32'(cipher_en), 32'd1);
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xor_cipher_cfg_ctrl.md
XOR_CIPHER_CFG_CTRL -- requirements
Module: xor_cipher_cfg_ctrl

Interface
REQ-001 Parameter CFG_LEN, default 8: length in bits of the cipher's serial configuration/key chain.
REQ-002 Parameter HB_BITS, default 4: heartbeat divider width; heartbeat toggles every 2^HB_BITS cycles.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 load_req  input  1  requester offers a new key in load_data.
REQ-006 load_data  input  CFG_LEN  key/config word; bit 0 shifted first.
REQ-007 load_rdy  output  1  controller can accept a load this cycle.
REQ-008 cfg_en  output  1  shift-enable for the cipher config chain.
REQ-009 cfg_sd  output  1  serial data into the cipher config chain.
REQ-010 cfg_so  input  1  serial data out of the cipher chain (cipher cfg_o); combinational view of the last stage.
REQ-011 cipher_en  output  1  cipher may encrypt/decrypt (e, d valid).
REQ-012 done  output  1  one-cycle pulse: load completed and verified.
REQ-013 err  output  1  sticky: last load failed readback.
REQ-014 heartbeat  output  1  free-running liveness toggle.

Function
REQ-015 States SHALL be IDLE, SHIFT, VERIFY, RUN, FAULT.
REQ-016 load_rdy SHALL be 1 in IDLE, RUN, FAULT and 0 in SHIFT, VERIFY.
REQ-017 Load accepted on an edge where load_req=1 and load_rdy=1; load_data captured into an internal shadow register that edge; load_data ignored thereafter.
REQ-018 On accept: next state SHIFT, bit counter cleared to 0, err cleared, cipher_en cleared (same edge).
REQ-019 SHIFT: cfg_en=1, cfg_sd=shadow[k] for counter k=0..CFG_LEN-1; exactly CFG_LEN cycles; after k=CFG_LEN-1, counter to 0, next VERIFY.
REQ-020 VERIFY: cfg_en=1, cfg_sd=shadow[k] again (re-shifting restores the chain); at each edge compare cfg_so against shadow[k]; exactly CFG_LEN cycles.
REQ-021 Any VERIFY mismatch SHALL set a mismatch flag; remaining VERIFY cycles still complete so the chain holds the full key.
REQ-022 End of VERIFY, no mismatch: next RUN, done=1 for the first RUN cycle only, cipher_en=1 throughout RUN.
REQ-023 End of VERIFY with mismatch: next FAULT, err=1, cipher_en=0, done not pulsed.
REQ-024 cfg_en SHALL be 0 in IDLE, RUN, FAULT; cfg_sd SHALL be 0 when cfg_en=0.
REQ-025 Accept-to-done latency SHALL be exactly 2*CFG_LEN+1 cycles (done high on edge 2*CFG_LEN+1 after accept edge).
REQ-026 load_req held high during SHIFT/VERIFY SHALL be ignored; a request still high when RUN/FAULT is entered SHALL be accepted on that state's first cycle (done pulse still emitted, cipher_en drops next edge).
REQ-027 FAULT is left only by a new accepted load; err stays 1 until then.
REQ-028 Heartbeat: HB_BITS-bit free-running counter; heartbeat toggles on counter wrap from all-ones to 0; unaffected by state.
REQ-029 Bit counter width SHALL be clog2(CFG_LEN), minimum 1; no wrap outside SHIFT/VERIFY.

Reset
REQ-030 rst=0 SHALL immediately force IDLE, counters 0, shadow 0, mismatch 0; outputs load_rdy=1, cfg_en=0, cfg_sd=0, cipher_en=0, done=0, err=0, heartbeat=0.
REQ-031 Reset mid-SHIFT/VERIFY SHALL abort the load; chain contents then undefined, cipher_en stays 0 until a later successful load.
REQ-032 Deassertion SHALL take effect on the next rising edge; no load accepted on the edge where rst is still 0.

Verification (CFG_LEN=8, HB_BITS=4, bench models an 8-stage chain)
REQ-033 Load 0xA5 -> cfg_sd sequence 1,0,1,0,0,1,0,1 twice over 16 cycles with cfg_en=1; done pulses 17 cycles after accept; cipher_en=1, err=0.
REQ-034 Chain model with stuck-at-0 output, load 0xFF -> FAULT, err=1, cipher_en=0, no done; then repair model, load 0x3C -> err clears on accept, done, cipher_en=1.
REQ-035 In RUN with 0xA5, load 0x5A -> cipher_en drops on accept edge, load_rdy=0 for 16 cycles, done, chain holds 0x5A.
REQ-036 Assert rst=0 at SHIFT cycle 3 -> all outputs reset values asynchronously; release, load 0x81 -> normal completion.
REQ-037 load_req held high continuously from reset with 0x0F -> loads back-to-back, each accept on first RUN cycle, done every 17 cycles.
REQ-038 Heartbeat toggles every 16 cycles from reset release regardless of load activity.
